// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct constants, ALU operation encoding and pipeline-register layouts for cpu.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a; the pipeline never stalls. Optional feature macro used by cpu: FORWARDING_EN.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    // IF/ID: fetched word and its byte address
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    // ID/EX: operands read in ID plus decoded control
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        alu_op_t     alu_op;
        logic        use_imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_we;
        logic        branch;
    } idex_t;

    // EX/MEM: ALU result, store data and branch resolution inputs
    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rt_val;
        logic [31:0] br_target;
        logic [4:0]  dst;
        logic        zero;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_we;
        logic        branch;
    } exmem_t;

    // MEM/WB: value to retire into the register file
    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  dst;
        logic        reg_we;
    } memwb_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: 32-bit add/sub/and/or/signed-slt with a zero flag used by beq.
// Latency: purely combinational.
// Backpressure: none.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_t     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_zero
);

    // Result select; arithmetic wraps, slt compares as signed
    always_comb begin
        o_result = 32'd0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            default: o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/cpu_id.sv
// cpu_id: instruction decode and 32x32 register file (REG[i]=i after reset, REG[0] hard zero).
// Latency: combinational decode/read; WB write lands on the rising edge ending WB.
// Backpressure: none. With FORWARDING_EN, reads bypass a same-cycle WB write; otherwise they see the array only.
module cpu_id
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  ifid_t  i_fd,
    input  memwb_t i_wb,
    output idex_t  o_de
);

    logic [31:0] REG [0:31];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [4:0]  w_unused_shamt;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    assign w_op           = i_fd.instr[31:26];
    assign w_rs           = i_fd.instr[25:21];
    assign w_rt           = i_fd.instr[20:16];
    assign w_rd           = i_fd.instr[15:11];
    assign w_unused_shamt = i_fd.instr[10:6];
    assign w_funct        = i_fd.instr[5:0];
    assign w_imm          = i_fd.instr[15:0];

    // Register file: identity pattern on reset, WB write at end of cycle, $0 never written
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                REG[i] <= 32'(i);
            end
        end else if (i_wb.reg_we && (i_wb.dst != 5'd0)) begin
            REG[i_wb.dst] <= i_wb.wdata;
        end
    end

    // Operand read; $0 always reads zero
    always_comb begin
`ifdef FORWARDING_EN
        if (w_rs == 5'd0) begin
            w_rs_val = 32'd0;
        end else if (i_wb.reg_we && (i_wb.dst == w_rs)) begin
            w_rs_val = i_wb.wdata;
        end else begin
            w_rs_val = REG[w_rs];
        end
        if (w_rt == 5'd0) begin
            w_rt_val = 32'd0;
        end else if (i_wb.reg_we && (i_wb.dst == w_rt)) begin
            w_rt_val = i_wb.wdata;
        end else begin
            w_rt_val = REG[w_rt];
        end
`else
        w_rs_val = (w_rs == 5'd0) ? 32'd0 : REG[w_rs];
        w_rt_val = (w_rt == 5'd0) ? 32'd0 : REG[w_rt];
`endif
    end

    // Decode: anything not recognised leaves every control bit clear (NOP)
    always_comb begin
        o_de        = '0;
        o_de.pc     = i_fd.pc;
        o_de.rs_val = w_rs_val;
        o_de.rt_val = w_rt_val;
        o_de.imm    = sext16(w_imm);
        o_de.rs     = w_rs;
        o_de.rt     = w_rt;
        o_de.alu_op = ALU_ADD;
        case (w_op)
            OP_RTYPE: begin
                o_de.dst = w_rd;
                case (w_funct)
                    FN_ADD: begin o_de.alu_op = ALU_ADD; o_de.reg_we = 1'b1; end
                    FN_SUB: begin o_de.alu_op = ALU_SUB; o_de.reg_we = 1'b1; end
                    FN_AND: begin o_de.alu_op = ALU_AND; o_de.reg_we = 1'b1; end
                    FN_OR:  begin o_de.alu_op = ALU_OR;  o_de.reg_we = 1'b1; end
                    FN_SLT: begin o_de.alu_op = ALU_SLT; o_de.reg_we = 1'b1; end
                    default: o_de.reg_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                o_de.dst     = w_rt;
                o_de.use_imm = 1'b1;
                o_de.reg_we  = 1'b1;
            end
            OP_LW: begin
                o_de.dst     = w_rt;
                o_de.use_imm = 1'b1;
                o_de.reg_we  = 1'b1;
                o_de.mem_rd  = 1'b1;
            end
            OP_SW: begin
                o_de.use_imm = 1'b1;
                o_de.mem_we  = 1'b1;
            end
            OP_BEQ: begin
                o_de.alu_op = ALU_SUB;
                o_de.branch = 1'b1;
            end
            default: o_de.reg_we = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_if.sv
// cpu_if: program counter and instruction memory; words past IM_DEPTH fetch as 0 (NOP).
// Latency: combinational fetch of instruction[PC>>2]; PC updates every rising edge.
// Backpressure: none; PC advances by 4 each cycle unless a MEM-resolved branch redirects it.
module cpu_if
    import cpu_pkg::*;
#(
    parameter int IM_DEPTH = 512
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    localparam int IM_AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;

    // Loaded from outside the design; never reset
    logic [31:0] instruction [0:IM_DEPTH-1];
    logic [31:0] PC;

    logic [29:0] w_word;
    logic        w_in_range;
    logic [1:0]  w_unused_pc;

    assign w_word      = PC[31:2];
    assign w_unused_pc = PC[1:0];
    assign w_in_range  = ({2'b00, w_word} < 32'(IM_DEPTH));
    assign o_instr     = w_in_range ? instruction[w_word[IM_AW-1:0]] : 32'd0;
    assign o_pc        = PC;

    // Program counter: sequential fetch, redirected at the end of a taken beq's MEM cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            PC <= 32'd0;
        end else if (i_br_taken) begin
            PC <= i_br_target;
        end else begin
            PC <= PC + 32'd4;
        end
    end

endmodule

// File: rtl/cpu_mem.sv
// cpu_mem: data memory (word addressed, index modulo DM_DEPTH, low 2 bits ignored) and beq resolution.
// Latency: combinational load data; store lands on the rising edge ending MEM.
// Backpressure: none. DM_DEPTH is expected to be a power of two so address bits wrap naturally.
module cpu_mem
    import cpu_pkg::*;
#(
    parameter int DM_DEPTH = 32
)
(
    input  logic        clk,
    input  logic        rst,
    input  exmem_t      i_em,
    output memwb_t      o_mw,
    output logic        o_br_taken,
    output logic [31:0] o_br_target
);

    localparam int DM_AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

    logic [31:0]      DM [0:DM_DEPTH-1];
    logic [DM_AW-1:0] w_idx;

    assign w_idx = i_em.alu_res[DM_AW+1:2];

    // Data memory: cleared on reset, written by sw
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DM_DEPTH; i++) begin
                DM[i] <= 32'd0;
            end
        end else if (i_em.mem_we) begin
            DM[w_idx] <= i_em.rt_val;
        end
    end

    // Writeback value: load data for lw, ALU result otherwise
    always_comb begin
        o_mw        = '0;
        o_mw.dst    = i_em.dst;
        o_mw.reg_we = i_em.reg_we;
        o_mw.wdata  = i_em.mem_rd ? DM[w_idx] : i_em.alu_res;
    end

    assign o_br_taken  = i_em.branch & i_em.zero;
    assign o_br_target = i_em.br_target;

endmodule

// File: rtl/cpu.sv
// cpu: 5-stage in-order MIPS-subset pipeline (IF, ID, EX, MEM, WB) with private instruction and data memories.
// Latency: instruction fetched in cycle n writes REG at end of cycle n+4; beq redirects PC at end of its MEM cycle.
// Backpressure: none, no stalls or flushes. FORWARDING_EN adds EX forwarding from EX/MEM and MEM/WB plus ID write bypass.
module cpu
    import cpu_pkg::*;
#(
    parameter int IM_DEPTH = 512,
    parameter int DM_DEPTH = 32
)
(
    input  logic clk,
    input  logic rst
);

    ifid_t       r_fd;
    idex_t       r_de;
    exmem_t      r_em;
    memwb_t      r_mw;

    logic [31:0] FD_PC;

    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;
    idex_t       w_de;
    exmem_t      w_em;
    memwb_t      w_mw;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic [31:0] w_opa;
    logic [31:0] w_rtv;
    logic [31:0] w_opb;
    logic [31:0] w_alu_res;
    logic        w_alu_zero;

    assign FD_PC = r_fd.pc;

    cpu_if #(.IM_DEPTH(IM_DEPTH)) IF (
        .clk         (clk),
        .rst         (rst),
        .i_br_taken  (w_br_taken),
        .i_br_target (w_br_target),
        .o_pc        (w_if_pc),
        .o_instr     (w_if_instr)
    );

    cpu_id ID (
        .clk  (clk),
        .rst  (rst),
        .i_fd (r_fd),
        .i_wb (r_mw),
        .o_de (w_de)
    );

`ifdef FORWARDING_EN
    // EX operands: EX/MEM result wins over MEM/WB result; $0 and non-writers never forward
    always_comb begin
        w_opa = r_de.rs_val;
        w_rtv = r_de.rt_val;
        if (r_em.reg_we && (r_em.dst != 5'd0) && (r_em.dst == r_de.rs)) begin
            w_opa = r_em.alu_res;
        end else if (r_mw.reg_we && (r_mw.dst != 5'd0) && (r_mw.dst == r_de.rs)) begin
            w_opa = r_mw.wdata;
        end
        if (r_em.reg_we && (r_em.dst != 5'd0) && (r_em.dst == r_de.rt)) begin
            w_rtv = r_em.alu_res;
        end else if (r_mw.reg_we && (r_mw.dst != 5'd0) && (r_mw.dst == r_de.rt)) begin
            w_rtv = r_mw.wdata;
        end
    end
`else
    logic [9:0] w_unused_srcs;
    assign w_unused_srcs = {r_de.rs, r_de.rt};

    // EX operands come straight from the values read in ID
    always_comb begin
        w_opa = r_de.rs_val;
        w_rtv = r_de.rt_val;
    end
`endif

    assign w_opb = r_de.use_imm ? r_de.imm : w_rtv;

    cpu_alu u_alu (
        .i_op     (r_de.alu_op),
        .i_a      (w_opa),
        .i_b      (w_opb),
        .o_result (w_alu_res),
        .o_zero   (w_alu_zero)
    );

    // EX/MEM next value, including the beq target PC+4+(imm<<2)
    always_comb begin
        w_em           = '0;
        w_em.alu_res   = w_alu_res;
        w_em.rt_val    = w_rtv;
        w_em.br_target = r_de.pc + 32'd4 + {r_de.imm[29:0], 2'b00};
        w_em.dst       = r_de.dst;
        w_em.zero      = w_alu_zero;
        w_em.reg_we    = r_de.reg_we;
        w_em.mem_rd    = r_de.mem_rd;
        w_em.mem_we    = r_de.mem_we;
        w_em.branch    = r_de.branch;
    end

    cpu_mem #(.DM_DEPTH(DM_DEPTH)) MEM (
        .clk         (clk),
        .rst         (rst),
        .i_em        (r_em),
        .o_mw        (w_mw),
        .o_br_taken  (w_br_taken),
        .o_br_target (w_br_target)
    );

    // Pipeline registers: reset empties every stage so nothing in flight retires
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fd <= '0;
            r_de <= '0;
            r_em <= '0;
            r_mw <= '0;
        end else begin
            r_fd.pc    <= w_if_pc;
            r_fd.instr <= w_if_instr;
            r_de       <= w_de;
            r_em       <= w_em;
            r_mw       <= w_mw;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs for the cpu pipeline with hand-computed register/memory expectations.
// Latency: checks sampled on the falling edge after a known number of rising edges.
// Backpressure: n/a.
module tb_cpu;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_reg [0:31];

    localparam logic [5:0] T_ADD  = 6'h20;
    localparam logic [5:0] T_SUB  = 6'h22;
    localparam logic [5:0] T_AND  = 6'h24;
    localparam logic [5:0] T_OR   = 6'h25;
    localparam logic [5:0] T_SLT  = 6'h2A;
    localparam logic [5:0] T_ADDU = 6'h21;
    localparam logic [5:0] T_ADDI = 6'h08;
    localparam logic [5:0] T_LW   = 6'h23;
    localparam logic [5:0] T_SW   = 6'h2B;
    localparam logic [5:0] T_BEQ  = 6'h04;
    localparam logic [5:0] T_ORI  = 6'h0D;

    cpu #(.IM_DEPTH(512), .DM_DEPTH(32)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_im();
        for (int i = 0; i < 512; i++) dut.IF.instruction[i] = 32'd0;
    endtask

    task automatic put(input int a, input logic [31:0] w);
        dut.IF.instruction[a] = w;
    endtask

    // rst low across exactly one rising edge; returns on a falling edge with rst still low
    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_identity();
        for (int i = 0; i < 32; i++) exp_reg[i] = 32'(i);
    endtask

    task automatic check_regs(input string prefix);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s_REG%0d", prefix, i), dut.ID.REG[i], exp_reg[i]);
        end
    endtask

    task automatic load_mem_prog();
        clear_im();
        put(0, enc_i(T_ADDI, 0, 7, -1));
        put(4, enc_i(T_SW, 0, 7, 8));
        put(5, enc_i(T_LW, 0, 8, 8));
        put(6, enc_r(7, 1, 11, T_SLT));
        put(7, enc_i(T_SW, 0, 1, 32'h8F));
        put(8, enc_i(T_LW, 0, 10, 12));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        clear_im();

        // Reset state
        cycles(2);
        exp_identity();
        check_regs("rst");
        check("rst_PC", dut.IF.PC, 32'd0);
        check("rst_FD_PC", dut.FD_PC, 32'd0);
        for (int i = 0; i < 32; i++) check($sformatf("rst_DM%0d", i), dut.MEM.DM[i], 32'd0);

        // Dependency chain, ALU ops, unsupported funct/opcode
        hold_reset();
        clear_im();
        put(0,  enc_r(1, 2, 3, T_ADD));
        put(4,  enc_r(3, 3, 4, T_ADD));
        put(8,  enc_r(4, 3, 4, T_ADD));
        put(9,  enc_r(6, 5, 11, T_SUB));
        put(10, enc_r(6, 5, 12, T_AND));
        put(11, enc_r(6, 5, 13, T_OR));
        put(12, enc_r(6, 5, 14, T_SLT));
        put(13, enc_r(10, 1, 9, T_SLT));
        put(14, enc_r(1, 10, 15, T_SLT));
        put(15, enc_r(1, 1, 20, T_ADDU));
        put(16, enc_i(T_ORI, 0, 21, 32'hFF));
        rst = 1'b1;
        cycles(10);
        check("chain_REG4_mid", dut.ID.REG[4], 32'd6);
        check("chain_REG3_mid", dut.ID.REG[3], 32'd3);
        check("run_PC", dut.IF.PC, 32'd40);
        check("run_FD_PC", dut.FD_PC, 32'd36);
        cycles(20);
        exp_identity();
        exp_reg[3]  = 32'd3;
        exp_reg[4]  = 32'd9;
        exp_reg[9]  = 32'd0;
        exp_reg[11] = 32'd1;
        exp_reg[12] = 32'd4;
        exp_reg[13] = 32'd7;
        exp_reg[14] = 32'd0;
        exp_reg[15] = 32'd1;
        check_regs("alu");

        // Back-to-back hazards at distances 1, 2 and 3
        hold_reset();
        clear_im();
        put(0, enc_r(1, 2, 5, T_ADD));
        put(1, enc_r(5, 5, 6, T_ADD));
        put(2, enc_r(5, 0, 8, T_ADD));
        put(3, enc_r(5, 0, 7, T_ADD));
        rst = 1'b1;
        cycles(15);
        check("haz_REG5", dut.ID.REG[5], 32'd3);
`ifdef FORWARDING_EN
        check("haz_d1_REG6", dut.ID.REG[6], 32'd6);
        check("haz_d2_REG8", dut.ID.REG[8], 32'd3);
        check("haz_d3_REG7", dut.ID.REG[7], 32'd3);
`else
        check("haz_d1_REG6", dut.ID.REG[6], 32'd10);
        check("haz_d2_REG8", dut.ID.REG[8], 32'd5);
        check("haz_d3_REG7", dut.ID.REG[7], 32'd5);
`endif

        // Memory, immediates, signed slt, address wrap
        hold_reset();
        load_mem_prog();
        rst = 1'b1;
        cycles(20);
        check("mem_DM2", dut.MEM.DM[2], 32'hFFFF_FFFF);
        check("mem_DM3_wrap", dut.MEM.DM[3], 32'd1);
        check("mem_DM0", dut.MEM.DM[0], 32'd0);
        check("mem_REG7", dut.ID.REG[7], 32'hFFFF_FFFF);
        check("mem_REG8", dut.ID.REG[8], 32'hFFFF_FFFF);
        check("mem_REG11_slt_neg", dut.ID.REG[11], 32'd1);
        check("mem_REG10", dut.ID.REG[10], 32'd1);

        // Reset asserted mid-run discards work in flight
        hold_reset();
        load_mem_prog();
        rst = 1'b1;
        cycles(6);
        check("mid_REG7_before", dut.ID.REG[7], 32'hFFFF_FFFF);
        hold_reset();
        check("mid_REG7_reinit", dut.ID.REG[7], 32'd7);
        check("mid_PC", dut.IF.PC, 32'd0);
        check("mid_FD_PC", dut.FD_PC, 32'd0);
        clear_im();
        rst = 1'b1;
        cycles(15);
        check("mid_DM2_lost", dut.MEM.DM[2], 32'd0);
        check("mid_REG8_lost", dut.ID.REG[8], 32'd8);
        check("mid_REG11_lost", dut.ID.REG[11], 32'd11);

        // Branches, $0 writes, fetch past the end of instruction memory
        hold_reset();
        clear_im();
        put(0,  enc_i(T_BEQ, 0, 0, 4));
        put(1,  enc_i(T_ADDI, 0, 12, 1));
        put(2,  enc_i(T_ADDI, 0, 13, 2));
        put(3,  enc_i(T_ADDI, 0, 14, 3));
        put(4,  enc_i(T_ADDI, 0, 15, 32'h55));
        put(5,  enc_r(1, 1, 0, T_ADD));
        put(6,  enc_r(0, 1, 18, T_ADD));
        put(7,  enc_i(T_ADDI, 0, 16, 32'h66));
        put(8,  enc_i(T_BEQ, 1, 2, 8));
        put(9,  enc_i(T_ADDI, 0, 17, 32'h77));
        put(10, enc_i(T_BEQ, 0, 0, 589));
        put(88, enc_i(T_ADDI, 0, 19, 32'h99));
        rst = 1'b1;
        cycles(4);
        check("br_FD_PC_slot3", dut.FD_PC, 32'd12);
        cycles(1);
        check("br_FD_PC_target", dut.FD_PC, 32'd20);
        check("br_PC_after_target", dut.IF.PC, 32'd24);
        cycles(25);
        check("br_PC_beyond_im", dut.IF.PC, 32'd2468);
        exp_identity();
        exp_reg[12] = 32'd1;
        exp_reg[13] = 32'd2;
        exp_reg[14] = 32'd3;
        exp_reg[16] = 32'h66;
        exp_reg[17] = 32'h77;
        exp_reg[18] = 32'd1;
        check_regs("br");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
